hwpe_stream_sink_realign: RTL and testbench

HWPE_STREAM_SINK_REALIGN -- requirements
Module: hwpe_stream_sink_realign

---
 rtl/hwpe_stream_sink_realign_if.sv | 16 +
 rtl/hwpe_stream_sink_realign.sv | 212 +++++++++++++++++++++
 tb/tb_hwpe_stream_sink_realign.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_sink_realign_if.sv
// hwpe_stream_intf_stream: valid/ready byte-strobed stream bundle.
//   source modport: drives valid, data and strb; samples ready.
//   sink modport:   samples valid, data and strb; drives ready.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_sink_realign.sv
// hwpe_stream_sink_realign: shifts a word-aligned input stream by a byte offset so it can be
// written to a misaligned destination. A job of len input beats gives len output beats for
// offset 0, or len+1 beats (with partial first/last strobes) otherwise.
//
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   clear_i           synchronous soft clear (aborts the job, no done)
//   start_i           job start pulse, samples offset_i / len_i
//   offset_i, len_i   destination byte misalignment, number of input beats
//   stream_i          word-aligned input stream (strb ignored)
//   stream_o          realigned output stream with byte strobes
//   busy_o, done_o    job active, one-cycle job-end pulse
//
// Optional feature: define HWPE_STREAM_SINK_REALIGN_OUT_REG_EN to place a 2-entry FIFO on the
// output (one cycle latency, full throughput). Default build is a zero-latency datapath.
module hwpe_stream_sink_realign #(
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned NB_BYTES = DATA_WIDTH / 8,
    localparam int unsigned OFF_W = $clog2(NB_BYTES)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [OFF_W-1:0]       offset_i,
    input  logic [15:0]            len_i,
    hwpe_stream_intf_stream.sink   stream_i,
    hwpe_stream_intf_stream.source stream_o,
    output logic                   busy_o,
    output logic                   done_o
);
    // Wide enough to hold DATA_WIDTH itself as a shift amount.
    localparam int unsigned SHW = OFF_W + 4;
    localparam logic [SHW-1:0] DW_SH = SHW'(DATA_WIDTH);
    localparam logic [NB_BYTES-1:0] STRB_ALL = '1;

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e                state_q, state_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  done_q, done_d;

    logic [OFF_W+2:0]      sh_l;
    logic [SHW-1:0]        sh_r;
    logic [DATA_WIDTH-1:0] carry, run_data, flush_data, int_data;
    logic [NB_BYTES-1:0]   strb_first, int_strb;
    logic                  int_valid, int_ready, in_ready;
    logic                  job_end, zero_len, end_evt, drain_busy;

    // Datapath: bytes carried over from the previous beat fill the low k bytes.
    always_comb begin
        sh_l       = {off_q, 3'b000};
        sh_r       = DW_SH - SHW'(sh_l);
        carry      = (off_q == '0) ? '0 : (hold_q >> sh_r);
        run_data   = (stream_i.data << sh_l) | carry;
        flush_data = carry;
        strb_first = STRB_ALL << off_q;
    end

    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        job_end   = 1'b0;
        zero_len  = 1'b0;
        int_valid = 1'b0;
        int_data  = flush_data;
        int_strb  = ~strb_first;
        in_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i && !drain_busy) begin
                    if (len_i != 16'd0) begin
                        off_d   = offset_i;
                        len_d   = len_i;
                        cnt_d   = '0;
                        hold_d  = '0;
                        state_d = StRun;
                    end else begin
                        zero_len = 1'b1;
                    end
                end
            end
            StRun: begin
                int_valid = stream_i.valid;
                int_data  = run_data;
                int_strb  = (cnt_q == 16'd0) ? strb_first : STRB_ALL;
                in_ready  = int_ready;
                if (stream_i.valid && int_ready) begin
                    cnt_d  = cnt_q + 16'd1;
                    hold_d = stream_i.data;
                    if (cnt_q + 16'd1 == len_q) begin
                        if (off_q == '0) begin
                            state_d = StIdle;
                            job_end = 1'b1;
                        end else begin
                            state_d = StFlush;
                        end
                    end
                end
            end
            StFlush: begin
                int_valid = 1'b1;
                if (int_ready) begin
                    state_d = StIdle;
                    job_end = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (clear_i) begin
            state_d  = StIdle;
            cnt_d    = '0;
            hold_d   = '0;
            job_end  = 1'b0;
            zero_len = 1'b0;
        end
    end

    always_comb begin
        done_d = !clear_i && (zero_len || end_evt);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            off_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

`ifdef HWPE_STREAM_SINK_REALIGN_OUT_REG_EN
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [NB_BYTES-1:0]   fifo_strb_q [2];
    logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]            fill_q, fill_d;
    logic                  drain_q, drain_d;
    logic                  push, pop;

    assign int_ready      = (fill_q != 2'd2);
    assign push           = int_valid && int_ready;
    assign pop            = (fill_q != 2'd0) && stream_o.ready;
    assign stream_o.valid = (fill_q != 2'd0);
    assign stream_o.data  = fifo_data_q[rd_ptr_q];
    assign stream_o.strb  = fifo_strb_q[rd_ptr_q];
    // The job is over once its last beat has left the FIFO.
    assign end_evt        = drain_q && pop && (fill_q == 2'd1);
    assign drain_busy     = drain_q;

    always_comb begin
        wr_ptr_d = push ? !wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop ? !rd_ptr_q : rd_ptr_q;
        fill_d   = fill_q + {1'b0, push} - {1'b0, pop};
        drain_d  = drain_q;
        if (job_end) begin
            drain_d = 1'b1;
        end else if (end_evt) begin
            drain_d = 1'b0;
        end
        if (clear_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            fill_d   = 2'd0;
            drain_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fill_q   <= 2'd0;
            drain_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            drain_q  <= drain_d;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= int_data;
                fifo_strb_q[wr_ptr_q] <= int_strb;
            end
        end
    end
`else
    assign int_ready      = stream_o.ready;
    assign stream_o.valid = int_valid;
    assign stream_o.data  = int_data;
    assign stream_o.strb  = int_strb;
    assign end_evt        = job_end;
    assign drain_busy     = 1'b0;
`endif

    assign stream_i.ready = in_ready;
    assign busy_o         = (state_q != StIdle) || drain_busy;
    assign done_o         = done_q;
endmodule

// File: tb/tb_hwpe_stream_sink_realign.sv
module tb_hwpe_stream_sink_realign;
    logic        clk = 1'b0;
    logic        rst, clr, st;
    logic [1:0]  off;
    logic [15:0] len;
    logic        busy, done;

    always #5 clk = ~clk;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s_in ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s_out ();

    hwpe_stream_sink_realign #(.DATA_WIDTH(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (clr),
        .start_i  (st),
        .offset_i (off),
        .len_i    (len),
        .stream_i (s_in),
        .stream_o (s_out),
        .busy_o   (busy),
        .done_o   (done)
    );

    typedef struct {
        logic        clr, st;
        logic [1:0]  off;
        logic [15:0] len;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        ov, ir;
        logic [31:0] od;
        logic [3:0]  os;
        logic        busy, done;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad = 0;

    function automatic vec_t mk(logic c, logic s, logic [1:0] o, logic [15:0] l, logic iv,
                                logic [31:0] id, logic ordy, logic ov, logic ir,
                                logic [31:0] od, logic [3:0] os, logic b, logic d);
        vec_t v;
        v.clr = c; v.st = s; v.off = o; v.len = l; v.iv = iv; v.id = id; v.ordy = ordy;
        v.ov = ov; v.ir = ir; v.od = od; v.os = os; v.busy = b; v.done = d;
        return v;
    endfunction

    task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    task automatic drive(logic c, logic s, logic [1:0] o, logic [15:0] l, logic iv,
                         logic [31:0] id, logic ordy);
        clr = c; st = s; off = o; len = l;
        s_in.valid = iv; s_in.data = id; s_out.ready = ordy;
    endtask

    initial begin
        // offset 0, len 3: pass-through
        vecs.push_back(mk(0, 1, 0, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'hA, 1, 1, 1, 32'hA, 4'hF, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'hB, 1, 1, 1, 32'hB, 4'hF, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'hC, 1, 1, 1, 32'hC, 4'hF, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // offset 1, len 2, one stall on the first beat and on the flush beat
        vecs.push_back(mk(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h44332211, 0, 1, 0, 32'h33221100, 4'hE, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h44332211, 1, 1, 1, 32'h33221100, 4'hE, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h88776655, 1, 1, 1, 32'h77665544, 4'hF, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h00000088, 4'h1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h00000088, 4'h1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        // offset 3, len 1, ready low for 5 cycles
        vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 0, 0, 1, 32'hDDCCBBAA, 0, 1, 0, 32'hAA000000, 4'h8, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'hDDCCBBAA, 1, 1, 1, 32'hAA000000, 4'h8, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h00DDCCBB, 4'h7, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h00DDCCBB, 4'h7, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        // len 0 start
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        // clear after 1 of 4 beats, then offset 2 job
        vecs.push_back(mk(0, 1, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h11111111, 1, 1, 1, 32'h11111111, 4'hF, 1, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'hDDCCBBAA, 0, 1, 0, 32'hBBAA0000, 4'hC, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'hDDCCBBAA, 1, 1, 1, 32'hBBAA0000, 4'hC, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0000DDCC, 4'h3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        // start pulses inside RUN must be ignored
        vecs.push_back(mk(0, 1, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 9, 1, 32'h5, 1, 1, 1, 32'h5, 4'hF, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 32'h6, 1, 1, 1, 32'h6, 4'hF, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        rst = 1'b1;
        s_in.strb = '0;
        drive(0, 0, 0, 0, 0, 0, 1);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", -1, 32'(s_out.valid), 0);
        chk("rst_ready", -1, 32'(s_in.ready), 0);
        chk("rst_busy", -1, 32'(busy), 0);
        chk("rst_done", -1, 32'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_valid", -1, 32'(s_out.valid), 0);
        chk("post_rst_ready", -1, 32'(s_in.ready), 0);
        chk("post_rst_busy", -1, 32'(busy), 0);
        chk("post_rst_done", -1, 32'(done), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].clr, vecs[i].st, vecs[i].off, vecs[i].len, vecs[i].iv, vecs[i].id,
                  vecs[i].ordy);
            #1;
            chk("out_valid", i, 32'(s_out.valid), 32'(vecs[i].ov));
            chk("in_ready", i, 32'(s_in.ready), 32'(vecs[i].ir));
            chk("busy", i, 32'(busy), 32'(vecs[i].busy));
            chk("done", i, 32'(done), 32'(vecs[i].done));
            if (vecs[i].ov) begin
                chk("out_data", i, s_out.data, vecs[i].od);
                chk("out_strb", i, 32'(s_out.strb), 32'(vecs[i].os));
            end
        end

        // clear wins over a simultaneous start
        @(negedge clk);
        drive(1, 1, 0, 2, 0, 0, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 32'h7, 1);
        #1;
        chk("clr_prio_busy", 100, 32'(busy), 0);
        chk("clr_prio_ready", 100, 32'(s_in.ready), 0);
        chk("clr_prio_valid", 100, 32'(s_out.valid), 0);

        // reset wins over a simultaneous start
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1, 1, 1, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 32'h7, 1);
        #1;
        chk("rst_prio_busy", 101, 32'(busy), 0);
        chk("rst_prio_valid", 101, 32'(s_out.valid), 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("rst_prio_done", 102, 32'(done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
